// File: rtl/s1_transceiver.sv
// RB1-side serial transceiver: uploads 8 transposed 21-bit frames from RB1, downloads 18 13-bit frames into RB1.
// Optional S1_DONE_STICKY_EN: S1_done stays high until reset instead of pulsing for one cycle.
module s1_transceiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       updown,
  output logic       S1_done,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q,
  inout  wire        sen,
  inout  wire        sd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RECV  = 3'd5;
  localparam logic [2:0] S_WRITE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]  r_state;
  logic [7:0]  r_mem [0:17];
  logic [4:0]  r_cnt;
  logic [4:0]  r_bit;
  logic [2:0]  r_n;
  logic [11:0] r_sh;
  logic [3:0]  r_rcnt;
  logic        r_done;
  logic        r_rw;
  logic [4:0]  r_a;
  logic [7:0]  r_d;

  logic [17:0] w_col;
  logic [20:0] w_frame;
  logic        w_sen_up;
  logic        w_sd_up;
  logic [12:0] w_word;
  logic        w_bit13;
  logic        w_rx_en;
  logic        w_up_phase;

  // Column n of the 18x8 buffer: row 0 lands in the frame's data MSB.
  always_comb begin
    w_col = '0;
    for (int i = 0; i < 18; i++)
      w_col[17-i] = r_mem[i][3'd7 - r_n];
  end

  assign w_frame  = {r_n, w_col};
  assign w_sen_up = (r_state != S_SEND);
  assign w_sd_up  = (r_state == S_SEND) ? w_frame[5'd20 - r_bit] : 1'b0;

  assign sen = updown ? 1'bz : w_sen_up;
  assign sd  = updown ? 1'bz : w_sd_up;

  assign w_word     = {r_sh, sd};
  assign w_bit13    = (r_rcnt == 4'd12) && !sen;
  assign w_rx_en    = (r_state == S_RECV) || (r_state == S_WRITE);
  assign w_up_phase = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_SEND) ||
                      (r_state == S_GAP)  || (r_state == S_WAIT);

  // Read data for the address issued last cycle arrives now.
  always_ff @(posedge clk) begin
    if (rst && r_state == S_LOAD && !updown)
      r_mem[r_cnt] <= RB1_Q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_n     <= '0;
      r_sh    <= '0;
      r_rcnt  <= '0;
      r_done  <= 1'b0;
      r_rw    <= 1'b1;
      r_a     <= '0;
      r_d     <= '0;
    end else begin
      r_rw <= 1'b1;
      if (w_rx_en) begin
        if (sen || r_rcnt == 4'd12) r_rcnt <= '0;
        else                        r_rcnt <= r_rcnt + 4'd1;
        if (!sen) r_sh <= w_word[11:0];
      end
      if (updown && w_up_phase) begin
        // Direction flip aborts any upload activity and hands the bus over.
        r_state <= S_RECV;
        r_cnt   <= '0;
        r_rcnt  <= '0;
        r_bit   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_LOAD;
            r_a     <= 5'd1;
            r_cnt   <= '0;
          end
          S_LOAD: begin
            r_cnt <= r_cnt + 5'd1;
            if (r_a != 5'd17) r_a <= r_a + 5'd1;
            if (r_cnt == 5'd17) begin
              r_state <= S_SEND;
              r_a     <= '0;
              r_bit   <= '0;
              r_n     <= '0;
            end
          end
          S_SEND: begin
            if (r_bit == 5'd20) begin
              r_bit   <= '0;
              r_state <= S_GAP;
            end else begin
              r_bit <= r_bit + 5'd1;
            end
          end
          S_GAP: begin
            if (r_n == 3'd7) r_state <= S_WAIT;
            else begin
              r_n     <= r_n + 3'd1;
              r_state <= S_SEND;
            end
          end
          S_WAIT: r_state <= S_WAIT;
          S_RECV: begin
            if (w_bit13 && w_word[12:8] <= 5'd17) begin
              r_a     <= w_word[12:8];
              r_d     <= w_word[7:0];
              r_rw    <= 1'b0;
              r_state <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (r_cnt == 5'd17) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 5'd1;
              r_state <= S_RECV;
            end
          end
          S_DONE: begin
`ifdef S1_DONE_STICKY_EN
            r_done <= 1'b1;
`else
            r_done <= 1'b0;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign S1_done = r_done;
  assign RB1_RW  = r_rw;
  assign RB1_A   = r_a;
  assign RB1_D   = r_d;

endmodule

// File: tb/tb_s1_transceiver.sv
// Randomized bench for s1_transceiver: RB1 SRAM model, frame decoder for upload, frame driver for download.
module tb_s1_transceiver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       updown = 1'b0;
  logic       S1_done, RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q;
  wire        sen, sd;
  logic       tb_en = 1'b0, tb_sen = 1'b1, tb_sd = 1'b0;

  logic [7:0] ram [0:31];
  logic [7:0] img [0:31];
  logic       ld = 1'b1;
  int         wr_cnt = 0;
  int         vecs = 0, errs = 0;

  assign sen = tb_en ? tb_sen : 1'bz;
  assign sd  = tb_en ? tb_sd  : 1'bz;

  always #5 clk = ~clk;

  s1_transceiver dut (
    .clk(clk), .rst(rst), .updown(updown), .S1_done(S1_done), .RB1_RW(RB1_RW),
    .RB1_A(RB1_A), .RB1_D(RB1_D), .RB1_Q(RB1_Q), .sen(sen), .sd(sd)
  );

  // Synchronous RB1: 1-cycle read latency, write when RB1_RW is low.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 32; i++) ram[i] <= img[i];
    end else if (!RB1_RW) begin
      ram[RB1_A] <= RB1_D;
      wr_cnt     <= wr_cnt + 1;
    end
    RB1_Q <= ram[RB1_A];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset(input logic ud);
    @(negedge clk);
    rst = 1'b0; updown = ud; tb_en = ud; tb_sen = 1'b1; tb_sd = 1'b0; ld = 1'b1;
    repeat (2) @(negedge clk);
    ld = 1'b0; rst = 1'b1;
  endtask

  task automatic run_upload(input string nm);
    logic [20:0] exp_f [0:7];
    logic [17:0] col;
    logic [20:0] f;
    logic        ok;
    int          k, w0;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 18; i++) col[17-i] = img[i][7-n];
      exp_f[n] = {n[2:0], col};
    end
    do_reset(1'b0);
    w0 = wr_cnt;
    k  = 0;
    while (sen !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_first_sen_le21"}, (k <= 21) ? 1 : 0, 1);
    for (int n = 0; n < 8; n++) begin
      f = '0; ok = 1'b1;
      for (int b = 0; b < 21; b++) begin
        if (sen !== 1'b0) ok = 1'b0;
        f = {f[19:0], sd};
        @(negedge clk);
      end
      chk($sformatf("%s_frame%0d", nm, n), f, exp_f[n]);
      chk($sformatf("%s_senlow%0d", nm, n), ok, 1);
      chk($sformatf("%s_gap%0d", nm, n), sen, 1);
      @(negedge clk);
    end
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (sen !== 1'b1 || sd !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_hold_idle"}, ok, 1);
    chk({nm, "_no_write"}, wr_cnt - w0, 0);
  endtask

  task automatic send_word(input logic [12:0] w);
    for (int b = 12; b >= 0; b--) begin
      tb_sen = 1'b0;
      tb_sd  = w[b];
      @(negedge clk);
    end
    tb_sen = 1'b1;
    tb_sd  = 1'b0;
  endtask

  task automatic run_download(input string nm, input int kind);
    logic [12:0] fr [$];
    logic [7:0]  exp_ram [0:17];
    int          perm [0:17];
    int          v, j, tmp, w0;
    logic        valid;
    for (int i = 0; i < 32; i++) img[i] = 8'hA5;
    for (int i = 0; i < 18; i++) begin
      exp_ram[i] = 8'hA5;
      perm[i] = i;
    end
    if (kind != 0)
      for (int i = 17; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
    for (int i = 0; i < 18; i++)
      fr.push_back({perm[i][4:0], (kind == 0) ? ~perm[i][7:0] : 8'($urandom)});
    if (kind == 0) fr.insert($urandom_range(17, 0), {5'd20, 8'h3C});
    else begin
      fr.insert($urandom_range(17, 0), {5'($urandom_range(31, 18)), 8'($urandom)});
      fr.insert($urandom_range(18, 0), {5'($urandom_range(31, 18)), 8'($urandom)});
    end
    do_reset(1'b1);
    @(negedge clk);
    w0 = wr_cnt;
    v  = 0;
    foreach (fr[q]) begin
      valid = (fr[q][12:8] <= 5'd17);
      send_word(fr[q]);
      chk($sformatf("%s_rw%0d", nm, q), RB1_RW, valid ? 1'b0 : 1'b1);
      if (valid) begin
        chk($sformatf("%s_addr%0d", nm, q), RB1_A, fr[q][12:8]);
        chk($sformatf("%s_data%0d", nm, q), RB1_D, fr[q][7:0]);
        exp_ram[fr[q][12:8]] = fr[q][7:0];
        v++;
      end
      @(negedge clk);
      chk($sformatf("%s_rw_back%0d", nm, q), RB1_RW, 1);
      chk($sformatf("%s_done%0d", nm, q), S1_done, (valid && v == 18) ? 1 : 0);
    end
    chk({nm, "_wr_count"}, wr_cnt - w0, 18);
    for (int i = 0; i < 18; i++)
      chk($sformatf("%s_ram%0d", nm, i), ram[i], exp_ram[i]);
    send_word({5'd3, 8'h77});
    chk({nm, "_done_no_write"}, RB1_RW, 1);
    @(negedge clk);
`ifdef S1_DONE_STICKY_EN
    chk({nm, "_done_after"}, S1_done, 1);
`else
    chk({nm, "_done_after"}, S1_done, 0);
`endif
    chk({nm, "_ram3_kept"}, ram[3], exp_ram[3]);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    rst = 1'b0; ld = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_done", S1_done, 0);
    chk("rst_rw", RB1_RW, 1);
    chk("rst_a", RB1_A, 0);
    chk("rst_d", RB1_D, 0);
    chk("rst_sen", sen, 1);
    chk("rst_sd", sd, 0);
    chk("rst_nowrite", wr_cnt, 0);

    for (int i = 0; i < 32; i++) img[i] = 8'hFF;
    run_upload("ff");
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    run_upload("zero");
    for (int i = 0; i < 32; i++) img[i] = 8'(i);
    run_upload("ramp");
    for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    run_upload("rand");

    // Reset mid-frame, then the full upload must restart from frame 0.
    for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    do_reset(1'b0);
    k = 0;
    while (sen !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk("mid_in_frame", sen, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_sen", sen, 1);
    run_upload("restart");

    run_download("dl_seq", 0);
    run_download("dl_rand", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
